// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared float format, operand pair and issue-state types
package fpu_pkg;
  localparam int FP_W     = 32;
  localparam int EXP_W    = 6;
  localparam int MAN_W    = 25;
  localparam int EXP_BIAS = 31;
  localparam int ST_W     = 4;

  // Bit positions inside the 4-bit FPU status word
  localparam int ST_INVALID   = 0;
  localparam int ST_DIVZERO   = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 3;

  typedef logic [FP_W-1:0] fp_word_t;

  typedef struct packed {
    fp_word_t a;
    fp_word_t b;
  } fp_pair_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RESULT = 2'd2
  } issue_state_t;

  function automatic logic [EXP_W-1:0] fp_exp(input fp_word_t w);
    return w[FP_W-2 -: EXP_W];
  endfunction
endpackage

// File: rtl/fpu_pair_fifo.sv
// rtl/fpu_pair_fifo.sv - DEPTH-entry FIFO of operand pairs with occupancy count
module fpu_pair_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_i,
  input  fp_pair_t                     push_data_i,
  input  logic                         pop_i,
  output fp_pair_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fp_pair_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  // Caller guarantees push only when not full and pop only when not empty
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + 1'b1;
      end else if (pop_i && !push_i) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fpu_issue_queue.sv
// rtl/fpu_issue_queue.sv - buffers operand pairs, holds them on the FPU and returns results in order
module fpu_issue_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int FPU_LATENCY = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FP_W-1:0]              in_op_a,
  input  logic [FP_W-1:0]              in_op_b,
  output logic [FP_W-1:0]              fpu_op_a,
  output logic [FP_W-1:0]              fpu_op_b,
  input  logic [FP_W-1:0]              fpu_data,
  input  logic [ST_W-1:0]              fpu_status,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FP_W-1:0]              out_data,
  output logic [ST_W-1:0]              out_status,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(FPU_LATENCY+1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FPU_LATENCY-1);

  issue_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FP_W-1:0]   op_a_q, op_b_q;
  logic [FP_W-1:0]   out_data_q;
  logic [ST_W-1:0]   out_status_q;
  logic              out_valid_q, out_valid_d;
  logic              push, pop, capture;
  logic [CW-1:0]     fifo_count;
  fp_pair_t          head;

  // Full queue blocks input even if a pop happens this cycle
  assign in_ready = (fifo_count < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  fpu_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ('{a: in_op_a, b: in_op_b}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          cnt_d   = CNT_RELOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          capture     = 1'b1;
          out_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        // Back-to-back issue: next pair goes out on the same edge as the handshake
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (fifo_count != '0) begin
            pop     = 1'b1;
            cnt_d   = CNT_RELOAD;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      if (pop) begin
        op_a_q <= head.a;
        op_b_q <= head.b;
      end
      if (capture) begin
        out_data_q   <= fpu_data;
        out_status_q <= fpu_status;
      end
    end
  end

  assign fpu_op_a   = op_a_q;
  assign fpu_op_b   = op_b_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_status = out_status_q;
  assign count      = fifo_count;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);
endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb/tb_fpu_issue_queue.sv - directed vector bench for fpu_issue_queue with stub and float-add FPU models
module tb_fpu_issue_queue;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 5;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [31:0]   in_op_a, in_op_b;
  logic [31:0]   fpu_op_a, fpu_op_b, fpu_data;
  logic [3:0]    fpu_status;
  logic          out_valid, out_ready;
  logic [31:0]   out_data;
  logic [3:0]    out_status;
  logic [CW-1:0] count;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  bit real_fpu = 1'b0;

  always #5 clock = ~clock;

  fpu_issue_queue #(.DEPTH(DEPTH), .FPU_LATENCY(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op_a    (in_op_a),
    .in_op_b    (in_op_b),
    .fpu_op_a   (fpu_op_a),
    .fpu_op_b   (fpu_op_b),
    .fpu_data   (fpu_data),
    .fpu_status (fpu_status),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status),
    .count      (count),
    .busy       (busy)
  );

  // Positive-normal adder for the team float format (bias 31, 25-bit mantissa)
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [5:0]  ex, ey, e;
    logic [26:0] mx, my, s, t;
    int          d;
    ex = x[30:25];
    ey = y[30:25];
    mx = {2'b01, x[24:0]};
    my = {2'b01, y[24:0]};
    if (ex < ey) begin
      t = mx; mx = my; my = t;
      e = ex; ex = ey; ey = e;
    end
    d  = int'(ex) - int'(ey);
    my = my >> d;
    s  = mx + my;
    e  = ex;
    if (s[26]) begin
      s = s >> 1;
      e = e + 6'd1;
    end
    return {1'b0, e, s[24:0]};
  endfunction

  // FPU model: result of the operands seen LAT-1 edges ago
  logic [35:0] pipe [LAT-1];
  always @(posedge clock) begin
    pipe[0] <= real_fpu ? {4'h0, fp_add(fpu_op_a, fpu_op_b)}
                        : {fpu_op_a[3:0], fpu_op_a + fpu_op_b};
    for (int k = 1; k < LAT-1; k++) pipe[k] <= pipe[k-1];
  end
  assign fpu_data   = pipe[LAT-2][31:0];
  assign fpu_status = pipe[LAT-2][35:32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic [3:0]  exp_s;
  } vec_t;

  vec_t        vec [7];
  logic [31:0] pa [6];
  logic [31:0] pb [6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, acc, got, last_rise;
    bit  hold_ok, stable_ok, blocked_ok, rdy, p6, prev_v, seen;
    logic [31:0] snap_d, snap_a, snap_b;
    logic [3:0]  snap_s;

    vec[0] = '{1'b1, 32'h3E000000, 32'h3E000000, 32'h40000000, 4'h0};
    vec[1] = '{1'b1, 32'h3F000000, 32'h3E000000, 32'h40800000, 4'h0};
    vec[2] = '{1'b1, 32'h40000000, 32'h3E000000, 32'h41000000, 4'h0};
    vec[3] = '{1'b0, 32'h00000005, 32'h00000003, 32'h00000008, 4'h5};
    vec[4] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'hF};
    vec[5] = '{1'b0, 32'h1234567A, 32'h11111111, 32'h2345678B, 4'hA};
    vec[6] = '{1'b0, 32'h8000000C, 32'h80000000, 32'h0000000C, 4'hC};
    for (int i = 0; i < 6; i++) begin
      pa[i] = 32'(32'h10000000 * (i + 1) + i + 3);
      pb[i] = 32'(32'h01010101 * (i + 1));
    end

    reset = 1'b1; in_valid = 1'b0; in_op_a = '0; in_op_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_fpu_op_a",  fpu_op_a,       32'd0);
    chk("rst_fpu_op_b",  fpu_op_b,       32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    reset = 1'b0;

    // Single pair into an idle block: latency, operand hold, pass-through data
    for (int i = 0; i < 7; i++) begin
      real_fpu = vec[i].rl;
      @(negedge clock);
      chk("vec_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_op_a = vec[i].a; in_op_b = vec[i].b;
      @(negedge clock);
      in_valid = 1'b0;
      cyc = 0; hold_ok = 1'b1;
      while (!out_valid && cyc < 20) begin
        @(negedge clock);
        cyc++;
        if (cyc <= LAT && (fpu_op_a !== vec[i].a || fpu_op_b !== vec[i].b)) hold_ok = 1'b0;
      end
      chk("vec_latency",    32'(cyc),        32'(LAT + 1));
      chk("vec_op_hold",    32'(hold_ok),    32'd1);
      chk("vec_out_data",   out_data,        vec[i].exp_d);
      chk("vec_out_status", 32'(out_status), 32'(vec[i].exp_s));
      @(negedge clock);
      chk("vec_valid_drop", 32'(out_valid),  32'd0);
      chk("vec_idle",       32'(busy),       32'd0);
    end
    real_fpu = 1'b0;

    // Fill while the consumer stalls: 1 in flight + DEPTH queued, then blocked
    out_ready = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 5 && cyc < 30) begin
      @(negedge clock);
      in_valid = 1'b1; in_op_a = pa[acc]; in_op_b = pb[acc];
      rdy = in_ready;
      @(posedge clock);
      if (rdy) acc++;
      cyc++;
    end
    chk("fill_accepted", 32'(acc), 32'd5);
    @(negedge clock);
    in_op_a = pa[5]; in_op_b = pb[5];
    chk("full_count",    32'(count),    32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("stall_valid",  32'(out_valid),  32'd1);
    chk("stall_data",   out_data,        pa[0] + pb[0]);
    chk("stall_status", 32'(out_status), 32'(pa[0][3:0]));
    snap_d = out_data; snap_s = out_status; snap_a = fpu_op_a; snap_b = fpu_op_b;
    stable_ok = 1'b1; blocked_ok = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (out_data !== snap_d || out_status !== snap_s || fpu_op_a !== snap_a ||
          fpu_op_b !== snap_b || count !== CW'(4) || out_valid !== 1'b1) stable_ok = 1'b0;
      if (in_ready !== 1'b0) blocked_ok = 1'b0;
    end
    chk("stall_stable",  32'(stable_ok),  32'd1);
    chk("stall_blocked", 32'(blocked_ok), 32'd1);
    chk("stall_op_a",    snap_a,          pa[0]);

    // Release: remaining results in push order, one every LAT+1 cycles
    out_ready = 1'b1;
    got = 1; last_rise = -1; cyc = 0; prev_v = 1'b1;
    while (got < 6 && cyc < 100) begin
      p6 = in_valid && in_ready;
      @(negedge clock);
      cyc++;
      if (p6) in_valid = 1'b0;
      if (out_valid && !prev_v) begin
        chk("drain_data",   out_data,        pa[got] + pb[got]);
        chk("drain_status", 32'(out_status), 32'(pa[got][3:0]));
        if (last_rise >= 0) chk("drain_interval", 32'(cyc - last_rise), 32'(LAT + 1));
        last_rise = cyc;
        got++;
      end
      prev_v = out_valid;
    end
    chk("drain_results", 32'(got), 32'd6);
    cyc = 0;
    while (busy && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("drain_idle", 32'(busy), 32'd0);

    // Reset while WAIT with two pairs queued discards everything
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      in_valid = 1'b1; in_op_a = pa[k]; in_op_b = pb[k];
      @(posedge clock);
    end
    @(negedge clock);
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_count",     32'(count),      32'd0);
    chk("mid_rst_busy",      32'(busy),       32'd0);
    chk("mid_rst_valid",     32'(out_valid),  32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),   32'd1);
    chk("mid_rst_fpu_op_a",  fpu_op_a,        32'd0);
    chk("mid_rst_out_data",  out_data,        32'd0);
    chk("mid_rst_status",    32'(out_status), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (out_valid || busy) seen = 1'b1;
    end
    chk("mid_rst_quiet", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
